uart_tx_arb: RTL and testbench

Round-robin arbiter that shares the single transmitter of `uart_m` among up to `NREQ` on-chip requesters. Each requester offers one byte at a time with a req/ack handshake. The arbiter latches the winning byte, pulses `load` into the UART and tracks `txbusy` until the character has left the shift register. A per-requester `lock` input keeps the transmitter for back-to-back bytes, so a multi-byte message is never interleaved with other traffic.

---
 rtl/uart_tx_arb.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_arb.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_m transmitter between NREQ byte requesters.
// A requester that holds lock keeps the transmitter for back-to-back bytes.
module uart_tx_arb #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned BUSYTMO = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   lock,
    input  logic [8*NREQ-1:0] din,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   gnt,
    output logic              load,
    output logic [7:0]        d,
    input  logic              txbusy,
    output logic              err
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(BUSYTMO + 1);
    // Counter clears in LOAD; matching this value in WAITHI makes err visible
    // exactly BUSYTMO cycles after the load strobe.
    localparam logic [CW-1:0] TMO_LAST = CW'(BUSYTMO - 2);
    localparam logic [CW-1:0] TMO_SAT  = CW'(BUSYTMO);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWaitHi,
        StWaitLo
    } state_e;

    state_e        state;
    logic [PW-1:0] ptr;
    logic [CW-1:0] cnt;

    logic [PW-1:0] own_idx;
    logic          own_lock;
    logic          own_req;
    logic          own_keeps;

    int unsigned   cand;
    logic          rr_found;
    logic [PW-1:0] rr_idx;

    logic          win;
    logic [PW-1:0] win_idx;
    logic [NREQ-1:0] win_oh;
    logic [PW-1:0] ptr_nxt;

    // Decode the current owner and whether its lock keeps the transmitter.
    always_comb begin
        own_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                own_idx = PW'(i);
            end
        end
        own_lock  = lock[own_idx];
        own_req   = req[own_idx];
        own_keeps = (|gnt) && own_lock;
    end

    // Round-robin search over req starting at ptr.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!rr_found && req[cand[PW-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = cand[PW-1:0];
            end
        end
    end

    // Pick the winner: a locked owner wins only with its own req, otherwise round-robin.
    always_comb begin
        if (own_keeps) begin
            win     = own_req;
            win_idx = own_idx;
        end else begin
            win     = rr_found;
            win_idx = rr_idx;
        end
        win_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            win_oh[i] = (win_idx == PW'(i));
        end
        if (32'(win_idx) == NREQ - 1) begin
            ptr_nxt = '0;
        end else begin
            ptr_nxt = win_idx + PW'(1);
        end
    end

    // Arbitration FSM with registered strobes, grant, data and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= StIdle;
            ptr   <= '0;
            cnt   <= '0;
            ack   <= '0;
            gnt   <= '0;
            load  <= 1'b0;
            d     <= 8'h00;
            err   <= 1'b0;
        end else begin
            load <= 1'b0;
            ack  <= '0;
            unique case (state)
                StIdle: begin
                    // A UART still busy (e.g. after reset) holds everything off.
                    if (!txbusy) begin
                        if (!own_keeps) begin
                            gnt <= '0;
                        end
                        if (win) begin
                            d     <= din[{win_idx, 3'b000} +: 8];
                            gnt   <= win_oh;
                            ptr   <= ptr_nxt;
                            load  <= 1'b1;
                            ack   <= win_oh;
                            state <= StLoad;
                        end
                    end
                end
                StLoad: begin
                    cnt   <= '0;
                    state <= StWaitHi;
                end
                StWaitHi: begin
                    if (txbusy) begin
                        state <= StWaitLo;
                    end else if (cnt == TMO_LAST) begin
                        err   <= 1'b1;
                        state <= StIdle;
                    end else if (cnt != TMO_SAT) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                StWaitLo: begin
                    // gnt is kept so IDLE can see the owner's lock.
                    if (!txbusy) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed scenarios plus random traffic
// checked against a round-robin/lock reference model.
module tb_uart_tx_arb;

    localparam int N   = 4;
    localparam int TMO = 15;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [8*N-1:0] din;
    logic [N-1:0]   ack;
    logic [N-1:0]   gnt;
    logic           load;
    logic [7:0]     d;
    logic           txbusy = 1'b0;
    logic           err;

    // UART model state
    logic uart_dead = 1'b0;
    int   char_len  = 30;
    int   rise_cnt  = 0;
    int   fall_cnt  = 0;

    // Reference model state
    int last_win;
    int owner;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_arb #(
        .NREQ   (N),
        .BUSYTMO(TMO)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .lock  (lock),
        .din   (din),
        .ack   (ack),
        .gnt   (gnt),
        .load  (load),
        .d     (d),
        .txbusy(txbusy),
        .err   (err)
    );

    // UART model: txbusy rises 2 cycles after load and stays high for char_len cycles.
    always @(posedge clk) begin
        if (load && !uart_dead) begin
            rise_cnt <= 1;
        end else if (rise_cnt > 0) begin
            rise_cnt <= rise_cnt - 1;
            if (rise_cnt == 1) begin
                txbusy   <= 1'b1;
                fall_cnt <= char_len;
            end
        end else if (fall_cnt > 0) begin
            fall_cnt <= fall_cnt - 1;
            if (fall_cnt == 1) begin
                txbusy <= 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Who should win next given the current request/lock vectors.
    function automatic int predict(input logic [N-1:0] r, input logic [N-1:0] l);
        int k;
        if (owner >= 0) begin
            if (l[owner]) begin
                if (r[owner]) return owner;
                return -1;
            end
        end
        for (int i = 1; i <= N; i++) begin
            k = (last_win + i) % N;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        last_win = N - 1;
        owner    = -1;
    endtask

    task automatic expect_load(input string tag, input int maxcyc, output int w);
        bit         seen;
        logic [N-1:0] exp_oh;
        logic [7:0] exp_d;
        seen = 1'b0;
        w    = -1;
        for (int c = 0; c < maxcyc && !seen; c++) begin
            @(negedge clk);
            if (load) seen = 1'b1;
        end
        check({tag, "/load"}, 32'(seen), 32'd1);
        if (seen) begin
            w      = predict(req, lock);
            exp_oh = (w >= 0) ? N'(1 << w) : '0;
            exp_d  = (w >= 0) ? din[8*w +: 8] : 8'h00;
            check({tag, "/ack"}, 32'(ack), 32'(exp_oh));
            check({tag, "/gnt"}, 32'(gnt), 32'(exp_oh));
            check({tag, "/d"}, 32'(d), 32'(exp_d));
            check({tag, "/idle_uart"}, 32'(txbusy), 32'd0);
            if (w >= 0) begin
                last_win = w;
                owner    = w;
            end
        end
    endtask

    task automatic wait_quiet(input string tag);
        int run;
        int c;
        run = 0;
        c   = 0;
        while (run < 4 && c < 3000) begin
            @(negedge clk);
            c++;
            if (!txbusy && !load) run++;
            else run = 0;
        end
        check({tag, "/quiet"}, 32'(run >= 4), 32'd1);
    endtask

    task automatic wait_char_done();
        bit hi;
        bit done;
        hi   = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            if (txbusy) hi = 1'b1;
            else if (hi) done = 1'b1;
        end
    endtask

    function automatic logic [7:0] rbyte();
        return 8'($urandom);
    endfunction

    function automatic logic rlock();
        return ($urandom_range(2, 0) == 0);
    endfunction

    initial begin
        int   w;
        int   i;
        bit   flag_a;
        bit   flag_b;
        int   order [5];

        order = '{0, 1, 2, 3, 0};
        rst  = 1'b1;
        req  = '0;
        lock = '0;
        din  = '0;
        model_reset();

        // Reset state
        @(negedge clk);
        check("reset/ack", 32'(ack), 32'd0);
        check("reset/gnt", 32'(gnt), 32'd0);
        check("reset/load", 32'(load), 32'd0);
        check("reset/d", 32'(d), 32'd0);
        check("reset/err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single requester, long character
        char_len    = 1040;
        din[7:0]    = 8'hA5;
        req         = 4'b0001;
        expect_load("single", 1, w);
        check("single/d_const", 32'(d), 32'hA5);
        check("single/ack_const", 32'(ack), 32'b0001);
        req    = '0;
        flag_a = 1'b1;
        flag_b = 1'b0;
        for (int c = 0; c < 1200; c++) begin
            @(negedge clk);
            if (gnt !== 4'b0001) flag_a = 1'b0;
            if (txbusy) flag_b = 1'b1;
            else if (flag_b) break;
        end
        check("single/gnt_held", 32'(flag_a), 32'd1);
        check("single/err", 32'(err), 32'd0);
        repeat (3) @(negedge clk);
        check("single/gnt_released", 32'(gnt), 32'd0);

        // Round-robin from a fresh pointer
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        char_len = 30;
        for (int k = 0; k < N; k++) din[8*k +: 8] = rbyte();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            expect_load("rr", 100, w);
            check("rr/order", 32'(gnt), 32'(1 << order[k]));
            if (w >= 0) din[8*w +: 8] = rbyte();
            if (k == 4) req = '0;
            @(negedge clk);
            check("rr/load_pulse", 32'(load), 32'd0);
        end
        wait_quiet("rr");

        // Locked three-byte message from requester 2 with requester 1 waiting
        din[23:16] = 8'h01;
        lock[2]    = 1'b1;
        req[2]     = 1'b1;
        expect_load("lock1", 100, w);
        check("lock1/d_const", 32'(d), 32'h01);
        din[23:16] = 8'h02;
        din[15:8]  = rbyte();
        req[1]     = 1'b1;
        expect_load("lock2", 100, w);
        check("lock2/d_const", 32'(d), 32'h02);
        din[23:16] = 8'h03;
        expect_load("lock3", 100, w);
        check("lock3/d_const", 32'(d), 32'h03);
        req[2]  = 1'b0;
        lock[2] = 1'b0;
        expect_load("lock_next", 100, w);
        check("lock_next/gnt_const", 32'(gnt), 32'b0010);
        req[1] = 1'b0;
        wait_quiet("lock");

        // Locked owner without req blocks everyone else
        din[7:0] = rbyte();
        lock[0]  = 1'b1;
        req[0]   = 1'b1;
        expect_load("starve0", 100, w);
        check("starve0/gnt_const", 32'(gnt), 32'b0001);
        req         = 4'b1000;
        din[31:24]  = rbyte();
        wait_char_done();
        flag_a = 1'b0;
        flag_b = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (load) flag_a = 1'b1;
            if (gnt !== 4'b0001) flag_b = 1'b0;
        end
        check("starve/no_load", 32'(flag_a), 32'd0);
        check("starve/gnt_kept", 32'(flag_b), 32'd1);
        lock[0] = 1'b0;
        expect_load("starve_rel", 5, w);
        check("starve_rel/gnt_const", 32'(gnt), 32'b1000);
        req = '0;
        wait_quiet("starve");

        // Random traffic against the model
        for (int t = 0; t < 40; t++) begin
            if (req == '0) begin
                i = $urandom_range(N - 1, 0);
                req[i]         = 1'b1;
                din[8*i +: 8]  = rbyte();
                lock[i]        = rlock();
            end
            char_len = $urandom_range(40, 5);
            expect_load("rand", 300, w);
            if (w >= 0) begin
                if (lock[w] || $urandom_range(1, 0) == 1) begin
                    din[8*w +: 8] = rbyte();
                    lock[w]       = rlock();
                end else begin
                    req[w]  = 1'b0;
                    lock[w] = 1'b0;
                end
                for (int j = 0; j < N; j++) begin
                    if (j != w && !req[j] && $urandom_range(3, 0) == 0) begin
                        req[j]        = 1'b1;
                        din[8*j +: 8] = rbyte();
                        lock[j]       = rlock();
                    end
                end
            end
        end
        req  = '0;
        lock = '0;
        wait_quiet("rand");

        // txbusy never rises: err after BUSYTMO cycles, service continues
        char_len   = 30;
        uart_dead  = 1'b1;
        din[15:8]  = rbyte();
        req[1]     = 1'b1;
        expect_load("tmo", 100, w);
        req[1] = 1'b0;
        flag_a = 1'b0;
        for (int k = 1; k < TMO; k++) begin
            @(negedge clk);
            if (err) flag_a = 1'b1;
        end
        check("tmo/err_early", 32'(flag_a), 32'd0);
        @(negedge clk);
        check("tmo/err_at_limit", 32'(err), 32'd1);
        uart_dead  = 1'b0;
        din[23:16] = rbyte();
        req[2]     = 1'b1;
        expect_load("tmo_next", 10, w);
        check("tmo_next/err_sticky", 32'(err), 32'd1);
        req = '0;
        wait_quiet("tmo");

        // Reset while waiting for txbusy to fall
        char_len   = 40;
        din[23:16] = rbyte() | 8'h80;
        req[2]     = 1'b1;
        expect_load("rst_pre", 100, w);
        req = '0;
        for (int c = 0; c < 10 && !txbusy; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid/ack", 32'(ack), 32'd0);
        check("rst_mid/gnt", 32'(gnt), 32'd0);
        check("rst_mid/load", 32'(load), 32'd0);
        check("rst_mid/d", 32'(d), 32'd0);
        check("rst_mid/err", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < N; k++) din[8*k +: 8] = rbyte();
        req    = 4'b1111;
        flag_a = 1'b0;
        for (int c = 0; c < 200 && txbusy; c++) begin
            @(negedge clk);
            if (load) flag_a = 1'b1;
        end
        check("rst_post/no_load_busy", 32'(flag_a), 32'd0);
        expect_load("rst_post", 5, w);
        check("rst_post/gnt_const", 32'(gnt), 32'b0001);
        req = '0;
        wait_quiet("rst_post");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
